// File: rtl/inst_rom_responder.sv
// Instruction-fetch responder: serves word fetches from an internal array after WAIT_CYCLES wait states.
// Optional completed-fetch counter is built when INST_ROM_FETCH_CNT_EN is defined.
module inst_rom_responder #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_en,
   input  logic [31:0]       rom_addr,
   output logic [31:0]       rom_inst,
   output logic              inst_valid,
   output logic              stall_request,
   output logic              addr_err,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   output logic [31:0]       fetch_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      state_q;
   logic [3:0]  wait_cnt_q;
   logic [31:0] addr_q;
   logic [31:0] rom_inst_q;
   logic        inst_valid_q;
   logic        addr_err_q;
   logic [31:0] mem [DEPTH];

   logic              accept_s;
   logic              resp_entry_s;
   logic [31:0]       fetch_addr_s;
   logic [ADDR_W-1:0] word_idx_s;
   logic              fetch_err_s;
   logic [31:0]       rd_word_s;

   // With zero wait states the response is built from the live request address on the accept edge.
   always_comb begin
      accept_s     = (state_q == IDLE) && rom_en && !load_en;
      resp_entry_s = (accept_s && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (wait_cnt_q <= 4'd1));
      if (state_q == IDLE) begin
         fetch_addr_s = rom_addr;
      end else begin
         fetch_addr_s = addr_q;
      end
      word_idx_s  = fetch_addr_s[ADDR_W+1:2];
      fetch_err_s = (fetch_addr_s[1:0] != 2'b00) ||
                    ((fetch_addr_s >> (ADDR_W + 2)) != 32'd0);
      if (fetch_err_s) begin
         rd_word_s = 32'h0000_0000;
      end else begin
         rd_word_s = mem[word_idx_s];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wait_cnt_q   <= 4'd0;
         addr_q       <= 32'h0000_0000;
         rom_inst_q   <= 32'h0000_0000;
         inst_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         inst_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         if (resp_entry_s) begin
            rom_inst_q   <= rd_word_s;
            inst_valid_q <= 1'b1;
            addr_err_q   <= fetch_err_s;
         end
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  addr_q     <= rom_addr;
                  wait_cnt_q <= WAIT_INIT;
                  state_q    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               wait_cnt_q <= wait_cnt_q - 4'd1;
               if (wait_cnt_q <= 4'd1) begin
                  state_q <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Array is not reset; the read above sees the pre-edge contents (read-before-write).
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   assign stall_request = ((state_q == IDLE) && rom_en) || (state_q == WAIT);
   assign rom_inst      = rom_inst_q;
   assign inst_valid    = inst_valid_q;
   assign addr_err      = addr_err_q;

`ifdef INST_ROM_FETCH_CNT_EN
   logic [31:0] fetch_count_q;
   logic [31:0] fetch_count_d;

   always_comb begin
      if (fetch_count_q == 32'hFFFF_FFFF) begin
         fetch_count_d = fetch_count_q;
      end else begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_q <= 32'h0000_0000;
      end else if (resp_entry_s) begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_inst_rom_responder.sv
// Scoreboard bench for inst_rom_responder: instances with WAIT_CYCLES 0, 1 and 2 share clk/rst.
module tb_inst_rom_responder;

   typedef struct {
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        rom_en        [3];
   logic [31:0] rom_addr      [3];
   logic [31:0] rom_inst      [3];
   logic        inst_valid    [3];
   logic        stall_request [3];
   logic        addr_err      [3];
   logic        load_en       [3];
   logic [9:0]  load_addr     [3];
   logic [31:0] load_data     [3];
   logic [31:0] fetch_count   [3];

   exp_t exp_q[$];
   int   n_vec;
   int   n_fail;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inst_rom_responder #(
         .DEPTH(1024),
         .ADDR_W(10),
         .WAIT_CYCLES(g)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .rom_en       (rom_en[g]),
         .rom_addr     (rom_addr[g]),
         .rom_inst     (rom_inst[g]),
         .inst_valid   (inst_valid[g]),
         .stall_request(stall_request[g]),
         .addr_err     (addr_err[g]),
         .load_en      (load_en[g]),
         .load_addr    (load_addr[g]),
         .load_data    (load_data[g]),
         .fetch_count  (fetch_count[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic load_word(input int idx, input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      load_en[idx]   = 1'b1;
      load_addr[idx] = a;
      load_data[idx] = d;
      @(negedge clk);
      load_en[idx]   = 1'b0;
   endtask

   task automatic issue(input int idx, input logic [31:0] addr, input logic [31:0] inst, input logic err);
      exp_t e;
      @(negedge clk);
      rom_en[idx]   = 1'b1;
      rom_addr[idx] = addr;
      e.inst = inst;
      e.err  = err;
      exp_q.push_back(e);
      @(negedge clk);
      rom_en[idx]   = 1'b0;
   endtask

   // lat counts acceptance-to-sample edges; issue() has already consumed one.
   task automatic wait_valid(input int idx, output int lat, output bit seen);
      lat  = 1;
      seen = inst_valid[idx];
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         seen = inst_valid[idx];
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (rom_inst[i] !== 32'h0 || inst_valid[i] !== 1'b0 || addr_err[i] !== 1'b0 ||
             stall_request[i] !== 1'b0 || fetch_count[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset[%0d]: got inst=%h v=%b e=%b st=%b cnt=%h want all zero",
                     i, rom_inst[i], inst_valid[i], addr_err[i], stall_request[i], fetch_count[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_fetch();
      exp_t e;
      load_word(1, 10'd3, 32'h2401_0005);
      @(negedge clk);
      rom_en[1]   = 1'b1;
      rom_addr[1] = 32'h0000_000C;
      e.inst = 32'h2401_0005;
      e.err  = 1'b0;
      exp_q.push_back(e);
      #1;
      n_vec++;
      if (stall_request[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL basic stall T: got %b want 1", stall_request[1]);
      end
      @(negedge clk);
      rom_en[1] = 1'b0;
      n_vec++;
      if (stall_request[1] !== 1'b1 || inst_valid[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL basic T+1: got stall=%b valid=%b want 1/0", stall_request[1], inst_valid[1]);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (inst_valid[1] !== 1'b1 || rom_inst[1] !== e.inst || addr_err[1] !== e.err) begin
         n_fail++;
         $display("FAIL basic T+2: got v=%b inst=%h err=%b want 1 %h %b",
                  inst_valid[1], rom_inst[1], addr_err[1], e.inst, e.err);
      end
      n_vec++;
      if (stall_request[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL basic stall RESP: got %b want 0", stall_request[1]);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      load_word(0, 10'd0, 32'h1111_1111);
      load_word(0, 10'd1, 32'h2222_2222);
      @(negedge clk);
      rom_en[0]   = 1'b1;
      rom_addr[0] = 32'h0;
      e.inst = 32'h1111_1111; e.err = 1'b0;
      exp_q.push_back(e);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if (inst_valid[0] !== 1'b1 || rom_inst[0] !== e.inst || stall_request[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b resp%0d: got v=%b inst=%h stall=%b want 1 %h 0",
                     k, inst_valid[0], rom_inst[0], stall_request[0], e.inst);
         end
         if (k == 0) begin
            rom_addr[0] = 32'h4;
            e.inst = 32'h2222_2222; e.err = 1'b0;
            exp_q.push_back(e);
            @(negedge clk);
            n_vec++;
            if (inst_valid[0] !== 1'b0 || stall_request[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b gap: got v=%b stall=%b want 0 1", inst_valid[0], stall_request[0]);
            end
         end
      end
      rom_en[0] = 1'b0;
   endtask

   task automatic test_errors();
      int          idx_t  [4] = '{1, 1, 0, 0};
      logic [31:0] addr_t [4] = '{32'h0000_000C, 32'h0000_0006, 32'h0000_0004, 32'h0000_1000};
      logic [31:0] inst_t [4] = '{32'h2401_0005, 32'h0, 32'h2222_2222, 32'h0};
      logic        err_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_t e;
      int lat;
      bit seen;
      for (int k = 0; k < 4; k++) begin
         issue(idx_t[k], addr_t[k], inst_t[k], err_t[k]);
         wait_valid(idx_t[k], lat, seen);
         e = exp_q.pop_front();
         n_vec++;
         if (!seen || lat != idx_t[k] + 1 || rom_inst[idx_t[k]] !== e.inst || addr_err[idx_t[k]] !== e.err) begin
            n_fail++;
            $display("FAIL err fetch %h: got seen=%b lat=%0d inst=%h err=%b want lat=%0d %h %b",
                     addr_t[k], seen, lat, rom_inst[idx_t[k]], addr_err[idx_t[k]], idx_t[k] + 1, e.inst, e.err);
         end
         @(negedge clk);
         n_vec++;
         if (addr_err[idx_t[k]] !== 1'b0 || inst_valid[idx_t[k]] !== 1'b0 || rom_inst[idx_t[k]] !== e.inst) begin
            n_fail++;
            $display("FAIL err after %h: got e=%b v=%b inst=%h want 0 0 %h",
                     addr_t[k], addr_err[idx_t[k]], inst_valid[idx_t[k]], rom_inst[idx_t[k]], e.inst);
         end
      end
   endtask

   task automatic test_load_collision();
      logic [31:0] want_t [2] = '{32'h5555_5555, 32'hAAAA_AAAA};
      exp_t e;
      int lat;
      bit seen;
      for (int k = 0; k < 2; k++) begin
         load_word(2, 10'd5, 32'hAAAA_AAAA);
         @(negedge clk);
         rom_en[2]   = 1'b1;
         rom_addr[2] = 32'h0000_0014;
         e.inst = want_t[k]; e.err = 1'b0;
         exp_q.push_back(e);
         @(negedge clk);
         rom_en[2] = 1'b0;
         if (k == 1) @(negedge clk);
         load_en[2]   = 1'b1;
         load_addr[2] = 10'd5;
         load_data[2] = 32'h5555_5555;
         @(negedge clk);
         load_en[2] = 1'b0;
         if (k == 0) @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if (inst_valid[2] !== 1'b1 || rom_inst[2] !== e.inst) begin
            n_fail++;
            $display("FAIL collision%0d: got v=%b inst=%h want 1 %h", k, inst_valid[2], rom_inst[2], e.inst);
         end
      end
      issue(2, 32'h0000_0014, 32'h5555_5555, 1'b0);
      wait_valid(2, lat, seen);
      e = exp_q.pop_front();
      n_vec++;
      if (!seen || lat != 3 || rom_inst[2] !== e.inst) begin
         n_fail++;
         $display("FAIL collision refetch: got seen=%b lat=%0d inst=%h want lat=3 %h", seen, lat, rom_inst[2], e.inst);
      end
   endtask

   task automatic test_priority();
      exp_t e;
      @(negedge clk);
      rom_en[1]    = 1'b1;
      rom_addr[1]  = 32'h0000_001C;
      load_en[1]   = 1'b1;
      load_addr[1] = 10'd7;
      load_data[1] = 32'h1234_5678;
      e.inst = 32'h1234_5678; e.err = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      load_en[1] = 1'b0;
      n_vec++;
      if (stall_request[1] !== 1'b1 || inst_valid[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL prio held: got stall=%b v=%b want 1 0", stall_request[1], inst_valid[1]);
      end
      @(negedge clk);
      rom_en[1] = 1'b0;
      n_vec++;
      if (inst_valid[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL prio early: got v=%b want 0", inst_valid[1]);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (inst_valid[1] !== 1'b1 || rom_inst[1] !== e.inst) begin
         n_fail++;
         $display("FAIL prio resp: got v=%b inst=%h want 1 %h", inst_valid[1], rom_inst[1], e.inst);
      end
   endtask

   task automatic test_reset_abort();
      bit any_valid;
      @(negedge clk);
      rom_en[2]   = 1'b1;
      rom_addr[2] = 32'h0000_0014;
      @(negedge clk);
      rom_en[2] = 1'b0;
      n_vec++;
      if (stall_request[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort pre: got stall=%b want 1", stall_request[2]);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (stall_request[2] !== 1'b0 || rom_inst[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL abort rst: got stall=%b inst=%h want 0 0", stall_request[2], rom_inst[2]);
      end
      @(negedge clk);
      rst = 1'b0;
      any_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         any_valid = any_valid | inst_valid[2];
      end
      n_vec++;
      if (any_valid !== 1'b0 || stall_request[2] !== 1'b0 || rom_inst[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL abort after: got v=%b stall=%b inst=%h want 0 0 0", any_valid, stall_request[2], rom_inst[2]);
      end
   endtask

   task automatic test_fetch_count();
      logic [31:0] addr_t [6] = '{32'h0C, 32'h1C, 32'h0C, 32'h1C, 32'h0C, 32'h02};
      logic [31:0] inst_t [6] = '{32'h2401_0005, 32'h1234_5678, 32'h2401_0005,
                                   32'h1234_5678, 32'h2401_0005, 32'h0};
      logic [31:0] exp_cnt;
      exp_t e;
      int lat;
      bit seen;
`ifdef INST_ROM_FETCH_CNT_EN
      exp_cnt = 32'd6;
`else
      exp_cnt = 32'd0;
`endif
      for (int k = 0; k < 6; k++) begin
         issue(1, addr_t[k], inst_t[k], (k == 5));
         wait_valid(1, lat, seen);
         e = exp_q.pop_front();
         n_vec++;
         if (!seen || lat != 2 || rom_inst[1] !== e.inst || addr_err[1] !== e.err) begin
            n_fail++;
            $display("FAIL cnt fetch%0d: got seen=%b lat=%0d inst=%h err=%b want lat=2 %h %b",
                     k, seen, lat, rom_inst[1], addr_err[1], e.inst, e.err);
         end
      end
      @(negedge clk);
      n_vec++;
      if (fetch_count[1] !== exp_cnt) begin
         n_fail++;
         $display("FAIL fetch_count: got %0d want %0d", fetch_count[1], exp_cnt);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
      end
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      rst    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rom_en[i]    = 1'b0;
         rom_addr[i]  = 32'h0;
         load_en[i]   = 1'b0;
         load_addr[i] = 10'd0;
         load_data[i] = 32'h0;
      end
      test_reset();
      test_basic_fetch();
      test_back_to_back();
      test_errors();
      test_load_collision();
      test_priority();
      test_reset_abort();
      test_fetch_count();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
